// File: rtl/reorder_buffer_p.sv
// Reorder buffer with multi-lane allocation, multi-port CDB writeback and in-order multi-lane retire.
// Entries form a circular window [head, head+count); flush trims the window back to a surviving entry.
module reorder_buffer_p #(
    parameter int DEPTH    = 16,
    parameter int ALLOC_W  = 4,
    parameter int CDB_W    = 4,
    parameter int COMMIT_W = 4,
    parameter int DATA_W   = 16,
    parameter int REG_W    = 4,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ALLOC_W-1:0]         alloc_valid,
    input  logic [ALLOC_W*REG_W-1:0]   alloc_rt,
    output logic                       alloc_ready,
    output logic [ALLOC_W*IDX_W-1:0]   alloc_idx,
    input  logic [CDB_W-1:0]           cdb_valid,
    input  logic [CDB_W*IDX_W-1:0]     cdb_idx,
    input  logic [CDB_W*DATA_W-1:0]    cdb_data,
    output logic [DEPTH-1:0]           rob_output_valid,
    output logic [DEPTH*DATA_W-1:0]    rob_output_values,
    output logic [COMMIT_W-1:0]        commit_valid,
    output logic [COMMIT_W*REG_W-1:0]  commit_rt,
    output logic [COMMIT_W*DATA_W-1:0] commit_data,
    output logic [COMMIT_W*IDX_W-1:0]  commit_idx,
    input  logic                       flush,
    input  logic [IDX_W-1:0]           flush_idx,
    output logic [IDX_W-1:0]           rob_head,
    output logic [IDX_W:0]             count,
    output logic                       full,
    output logic                       empty
);

    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   ALLOC_C = (IDX_W+1)'(ALLOC_W);
    localparam logic [IDX_W:0]   ONE_C   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);

    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_done;
    logic [REG_W-1:0]   r_rt    [DEPTH];
    logic [DATA_W-1:0]  r_value [DEPTH];
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;

    logic               w_flush_ok;
    logic [IDX_W-1:0]   w_flush_off;
    logic [DEPTH-1:0]   w_flush_clr;
    logic [DEPTH-1:0]   w_commit_clr;
    logic [IDX_W:0]     w_commit_n;
    logic               w_chain;
    logic [IDX_W-1:0]   w_cslot;
    logic               w_alloc_go;
    logic [IDX_W:0]     w_alloc_n;
    logic [IDX_W-1:0]   w_aslot;
    logic [IDX_W-1:0]   w_cidx;
    logic [DEPTH-1:0]   w_busy_n;
    logic [DEPTH-1:0]   w_done_n;
    logic [REG_W-1:0]   w_rt_n    [DEPTH];
    logic [DATA_W-1:0]  w_value_n [DEPTH];
    logic [IDX_W-1:0]   w_head_n;
    logic [IDX_W-1:0]   w_tail_n;
    logic [IDX_W:0]     w_count_n;
    logic [IDX_W:0]     w_cnt_flush;

    // Admission depends only on the registered occupancy, never on same-cycle retirement.
    assign alloc_ready = ((DEPTH_C - r_count) >= ALLOC_C);

    // Flush qualification and the set of entries younger than the surviving one (age = offset from head).
    always_comb begin
        w_flush_ok  = flush & r_busy[flush_idx];
        w_flush_off = flush_idx - r_head;
        w_flush_clr = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_flush_clr[e] = w_flush_ok & r_busy[e] & ((IDX_W'(e) - r_head) > w_flush_off);
        end
    end

    // In-order retire: lane k commits only while every entry from head up to head+k is done.
    always_comb begin
        commit_valid = '0;
        commit_rt    = '0;
        commit_data  = '0;
        commit_idx   = '0;
        w_commit_clr = '0;
        w_commit_n   = '0;
        w_chain      = 1'b1;
        w_cslot      = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_cslot = r_head + IDX_W'(k);
            w_chain = w_chain & r_busy[w_cslot] & r_done[w_cslot];
            commit_valid[k]                    = w_chain;
            commit_rt[k*REG_W +: REG_W]        = r_rt[w_cslot];
            commit_data[k*DATA_W +: DATA_W]    = r_value[w_cslot];
            commit_idx[k*IDX_W +: IDX_W]       = w_cslot;
            w_commit_clr[w_cslot]              = w_commit_clr[w_cslot] | w_chain;
            w_commit_n                         = w_commit_n + (IDX_W+1)'(w_chain);
        end
    end

    // Per-entry next state: CDB writes, then retire/flush clears, then fresh allocations.
    always_comb begin
        w_busy_n   = r_busy;
        w_done_n   = r_done;
        w_rt_n     = r_rt;
        w_value_n  = r_value;
        w_alloc_go = alloc_ready & ~w_flush_ok;
        w_alloc_n  = '0;
        w_aslot    = '0;
        w_cidx     = '0;
        alloc_idx  = '0;
        for (int p = 0; p < CDB_W; p++) begin
            w_cidx = cdb_idx[p*IDX_W +: IDX_W];
            if (cdb_valid[p] && r_busy[w_cidx] && !w_flush_clr[w_cidx]) begin
                w_value_n[w_cidx] = cdb_data[p*DATA_W +: DATA_W];
                w_done_n[w_cidx]  = 1'b1;
            end else begin
                w_done_n[w_cidx]  = w_done_n[w_cidx];
            end
        end
        for (int e = 0; e < DEPTH; e++) begin
            if (w_commit_clr[e] || w_flush_clr[e]) begin
                w_busy_n[e] = 1'b0;
                w_done_n[e] = 1'b0;
            end else begin
                w_busy_n[e] = w_busy_n[e];
            end
        end
        // Valid lanes pack densely from tail in lane order.
        for (int i = 0; i < ALLOC_W; i++) begin
            w_aslot = r_tail + w_alloc_n[IDX_W-1:0];
            alloc_idx[i*IDX_W +: IDX_W] = w_aslot;
            if (alloc_valid[i] && w_alloc_go) begin
                w_busy_n[w_aslot] = 1'b1;
                w_done_n[w_aslot] = 1'b0;
                w_rt_n[w_aslot]   = alloc_rt[i*REG_W +: REG_W];
            end else begin
                w_busy_n[w_aslot] = w_busy_n[w_aslot];
            end
            w_alloc_n = w_alloc_n + (IDX_W+1)'(alloc_valid[i]);
        end
    end

    // Pointer and occupancy update; after a flush the window is head_next..flush_idx.
    always_comb begin
        w_head_n    = r_head + w_commit_n[IDX_W-1:0];
        w_cnt_flush = {1'b0, w_flush_off} + ONE_C - w_commit_n;
        if (w_flush_ok) begin
            w_tail_n = flush_idx + ONE_I;
            if (w_cnt_flush > DEPTH_C) begin
                w_count_n = {1'b0, w_cnt_flush[IDX_W-1:0]};
            end else begin
                w_count_n = w_cnt_flush;
            end
        end else if (w_alloc_go) begin
            w_tail_n  = r_tail + w_alloc_n[IDX_W-1:0];
            w_count_n = r_count + w_alloc_n - w_commit_n;
        end else begin
            w_tail_n  = r_tail;
            w_count_n = r_count - w_commit_n;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_head  <= w_head_n;
            r_tail  <= w_tail_n;
            r_count <= w_count_n;
        end
    end

    // Payload storage; only meaningful while the matching busy/done flags are set.
    always_ff @(posedge clk) begin
        r_rt    <= w_rt_n;
        r_value <= w_value_n;
    end

    // Flatten per-entry values onto the observation bus.
    always_comb begin
        rob_output_values = '0;
        for (int e = 0; e < DEPTH; e++) begin
            rob_output_values[e*DATA_W +: DATA_W] = r_value[e];
        end
    end

    assign rob_output_valid = r_done;
    assign rob_head         = r_head;
    assign count            = r_count;
    assign full             = (r_count == DEPTH_C);
    assign empty            = (r_count == '0);

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Random and directed stimulus for reorder_buffer_p checked against a queue-based program-order model.
module tb_reorder_buffer_p;

    localparam int DEPTH    = 16;
    localparam int ALLOC_W  = 4;
    localparam int CDB_W    = 4;
    localparam int COMMIT_W = 4;
    localparam int DATA_W   = 16;
    localparam int REG_W    = 4;
    localparam int IDX_W    = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [ALLOC_W-1:0]         alloc_valid;
    logic [ALLOC_W*REG_W-1:0]   alloc_rt;
    logic                       alloc_ready;
    logic [ALLOC_W*IDX_W-1:0]   alloc_idx;
    logic [CDB_W-1:0]           cdb_valid;
    logic [CDB_W*IDX_W-1:0]     cdb_idx;
    logic [CDB_W*DATA_W-1:0]    cdb_data;
    logic [DEPTH-1:0]           rob_output_valid;
    logic [DEPTH*DATA_W-1:0]    rob_output_values;
    logic [COMMIT_W-1:0]        commit_valid;
    logic [COMMIT_W*REG_W-1:0]  commit_rt;
    logic [COMMIT_W*DATA_W-1:0] commit_data;
    logic [COMMIT_W*IDX_W-1:0]  commit_idx;
    logic                       flush;
    logic [IDX_W-1:0]           flush_idx;
    logic [IDX_W-1:0]           rob_head;
    logic [IDX_W:0]             count;
    logic                       full;
    logic                       empty;

    always #5 clk = ~clk;

    reorder_buffer_p #(
        .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CDB_W(CDB_W), .COMMIT_W(COMMIT_W),
        .DATA_W(DATA_W), .REG_W(REG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rt(alloc_rt), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
        .rob_output_valid(rob_output_valid), .rob_output_values(rob_output_values),
        .commit_valid(commit_valid), .commit_rt(commit_rt), .commit_data(commit_data), .commit_idx(commit_idx),
        .flush(flush), .flush_idx(flush_idx), .rob_head(rob_head), .count(count),
        .full(full), .empty(empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: program-order queue of live entry indices plus per-entry payload.
    int                q[$];
    logic              m_done [DEPTH];
    logic [DATA_W-1:0] m_val  [DEPTH];
    logic [REG_W-1:0]  m_rt   [DEPTH];
    int                m_head;
    int                m_tail;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qpos(input int e);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] == e) return i;
        end
        return -1;
    endfunction

    function automatic int commit_cnt();
        int c = 0;
        while (c < COMMIT_W && c < q.size() && m_done[q[c]]) c++;
        return c;
    endfunction

    task automatic drive_idle();
        alloc_valid = '0; alloc_rt = '0;
        cdb_valid = '0; cdb_idx = '0; cdb_data = '0;
        flush = 1'b0; flush_idx = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        q.delete();
        for (int e = 0; e < DEPTH; e++) m_done[e] = 1'b0;
        m_head = 0;
        m_tail = 0;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_ready", alloc_ready, 1);
        check_eq("rst_commit_valid", commit_valid, 0);
        check_eq("rst_rob_valid", rob_output_valid, 0);
        check_eq("rst_head", rob_head, 0);
        rst = 1'b0;
    endtask

    // One clock: drive inputs, check every output against the model, advance the model, clock the DUT.
    task automatic cycle(input logic [3:0] av, input logic [15:0] art, input logic [3:0] cv,
                         input logic [15:0] ci, input logic [63:0] cd, input logic fl, input logic [3:0] fi);
        logic [255:0] ev, mk;
        int c, pre, p, pos, e;
        logic rdy, fok;
        alloc_valid = av; alloc_rt = art;
        cdb_valid = cv; cdb_idx = ci; cdb_data = cd;
        flush = fl; flush_idx = fi;
        #1;
        rdy = ((DEPTH - q.size()) >= ALLOC_W);
        check_eq("alloc_ready", alloc_ready, rdy);
        check_eq("count", count, q.size());
        check_eq("full", full, q.size() == DEPTH);
        check_eq("empty", empty, q.size() == 0);
        check_eq("rob_head", rob_head, m_head);
        c = commit_cnt();
        ev = '0;
        for (int k = 0; k < c; k++) ev[k] = 1'b1;
        check_eq("commit_valid", commit_valid, ev);
        ev = '0; mk = '0;
        for (int k = 0; k < c; k++) begin
            ev[k*IDX_W +: IDX_W] = IDX_W'(q[k]);
            mk[k*IDX_W +: IDX_W] = '1;
        end
        check_eq("commit_idx", commit_idx & mk, ev);
        ev = '0; mk = '0;
        for (int k = 0; k < c; k++) begin
            ev[k*REG_W +: REG_W] = m_rt[q[k]];
            mk[k*REG_W +: REG_W] = '1;
        end
        check_eq("commit_rt", commit_rt & mk, ev);
        ev = '0; mk = '0;
        for (int k = 0; k < c; k++) begin
            ev[k*DATA_W +: DATA_W] = m_val[q[k]];
            mk[k*DATA_W +: DATA_W] = '1;
        end
        check_eq("commit_data", commit_data & mk, ev);
        ev = '0;
        for (int k = 0; k < DEPTH; k++) ev[k] = m_done[k];
        check_eq("rob_valid", rob_output_valid, ev);
        ev = '0; mk = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (m_done[k]) begin
                ev[k*DATA_W +: DATA_W] = m_val[k];
                mk[k*DATA_W +: DATA_W] = '1;
            end
        end
        check_eq("rob_values", rob_output_values & mk, ev);
        ev = '0; mk = '0; pre = 0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (av[i]) begin
                ev[i*IDX_W +: IDX_W] = IDX_W'((m_tail + pre) % DEPTH);
                mk[i*IDX_W +: IDX_W] = '1;
                pre++;
            end
        end
        check_eq("alloc_idx", alloc_idx & mk, ev);

        p = qpos(fi);
        fok = fl && (p >= 0);
        for (int j = 0; j < CDB_W; j++) begin
            if (cv[j]) begin
                pos = qpos(ci[j*IDX_W +: IDX_W]);
                if (pos >= 0 && !(fok && pos > p)) begin
                    m_val[ci[j*IDX_W +: IDX_W]]  = cd[j*DATA_W +: DATA_W];
                    m_done[ci[j*IDX_W +: IDX_W]] = 1'b1;
                end
            end
        end
        for (int k = 0; k < c; k++) begin
            e = q.pop_front();
            m_done[e] = 1'b0;
        end
        m_head = (m_head + c) % DEPTH;
        if (fok) begin
            while (q.size() > p + 1 - c) begin
                e = q.pop_back();
                m_done[e] = 1'b0;
            end
            m_tail = (fi + 1) % DEPTH;
        end else if (rdy) begin
            for (int i = 0; i < ALLOC_W; i++) begin
                if (av[i]) begin
                    q.push_back(m_tail);
                    m_done[m_tail] = 1'b0;
                    m_rt[m_tail]   = art[i*REG_W +: REG_W];
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    logic [3:0]  s_av, s_cv, s_fi;
    logic [15:0] s_art, s_ci;
    logic [63:0] s_cd;
    logic        s_fl;
    int          s_pct, s_pos, s_nc;

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        do_reset();

        // Lanes 0,1,3 pack into entries 0,1,2.
        cycle(4'b1011, {4'd3, 4'd0, 4'd2, 4'd1}, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        check_eq("d_cnt3", count, 3);
        check_eq("d_tail3", alloc_idx[3:0], 3);

        // Four bursts fill the buffer; a fifth is refused.
        do_reset();
        repeat (5) cycle(4'hF, 16'($urandom), 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        check_eq("d_full_cnt", count, 16);
        check_eq("d_full", full, 1);
        check_eq("d_full_ready", alloc_ready, 0);

        // Done holes stop retirement at the first not-done entry.
        do_reset();
        cycle(4'hF, 16'h4321, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        cycle(4'h0, 16'd0, 4'b0111, {4'd0, 4'd3, 4'd1, 4'd0}, {$urandom, $urandom}, 1'b0, 4'd0);
        check_eq("d_cv0011", commit_valid, 4'b0011);
        check_eq("d_cidx01", commit_idx[7:0], 8'h10);
        cycle(4'h0, 16'd0, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        check_eq("d_head2", rob_head, 2);

        // Flush at entry 3 with a same-cycle CDB write to a flushed entry.
        do_reset();
        cycle(4'hF, 16'h1111, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        cycle(4'hF, 16'h2222, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);
        cycle(4'h0, 16'd0, 4'b0001, 16'h0005, 64'h0000_0000_0000_BEEF, 1'b1, 4'd3);
        check_eq("d_flush_cnt", count, 4);
        check_eq("d_flush_e5", rob_output_valid[5], 0);
        check_eq("d_flush_tail", alloc_idx[3:0], 4);
        cycle(4'hF, 16'h3333, 4'd0, 16'd0, 64'd0, 1'b0, 4'd0);

        // Randomized traffic with alternating fill and drain phases.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) do_reset();
            s_pct = (((cyc / 150) % 2) == 0) ? 20 : 85;
            s_av  = 4'($urandom_range(0, 15));
            s_art = 16'($urandom);
            s_cd  = {$urandom, $urandom};
            s_cv  = '0;
            s_ci  = '0;
            for (int j = 0; j < CDB_W; j++) begin
                if ($urandom_range(0, 99) < s_pct) begin
                    s_cv[j] = 1'b1;
                    if (q.size() > 0 && $urandom_range(0, 9) < 8)
                        s_ci[j*IDX_W +: IDX_W] = IDX_W'(q[$urandom_range(0, q.size() - 1)]);
                    else
                        s_ci[j*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 15));
                end
            end
            s_fl = 1'b0;
            s_fi = '0;
            if ($urandom_range(0, 19) == 0) begin
                s_fi  = 4'($urandom_range(0, 15));
                s_pos = qpos(s_fi);
                s_nc  = commit_cnt();
                if (s_pos < 0) begin
                    s_fl = 1'b1;
                    s_av = '0;
                end else if (s_pos >= s_nc) begin
                    s_fl = 1'b1;
                end
            end
            cycle(s_av, s_art, s_cv, s_ci, s_cd, s_fl, s_fi);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reorder_buffer_p.md
REORDER_BUFFER_P -- requirements
Module: reorder_buffer_p

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of two, minimum 4.
REQ-002 SHALL have parameter ALLOC_W, default 4: allocation lanes per cycle; must be ≤ DEPTH.
REQ-003 SHALL have parameter CDB_W, default 4: CDB write ports.
REQ-004 SHALL have parameter COMMIT_W, default 4: retire lanes per cycle.
REQ-005 SHALL have parameters DATA_W, default 16, and REG_W, default 4; IDX_W = log2(DEPTH).
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk, input, 1; rst, input, 1.
REQ-007 SHALL have ports:
- alloc_valid, input, ALLOC_W: lane requests an entry.
- alloc_rt, input, ALLOC_W*REG_W: destination register per lane.
- alloc_ready, output, 1: at least ALLOC_W entries free.
- alloc_idx, output, ALLOC_W*IDX_W: entry index granted per lane.
REQ-008 SHALL have ports:
- cdb_valid, input, CDB_W: result write strobes.
- cdb_idx, input, CDB_W*IDX_W: target entry per port.
- cdb_data, input, CDB_W*DATA_W: result value per port.
REQ-009 SHALL have ports:
- rob_output_valid, output, DEPTH: per-entry done flag.
- rob_output_values, output, DEPTH*DATA_W: per-entry value.
REQ-010 SHALL have ports:
- commit_valid, output, COMMIT_W: retiring entries this cycle.
- commit_rt, output, COMMIT_W*REG_W: destination per commit lane.
- commit_data, output, COMMIT_W*DATA_W: value per commit lane.
- commit_idx, output, COMMIT_W*IDX_W: entry index (writer tag) per commit lane.
REQ-011 SHALL have ports:
- flush, input, 1: mispredict recovery strobe.
- flush_idx, input, IDX_W: surviving youngest entry.
- rob_head, output, IDX_W: oldest entry pointer.
- count, output, IDX_W+1: occupied entries.
- full, output, 1: count==DEPTH.
- empty, output, 1: count==0.

Function
REQ-012 SHALL keep per-entry busy, done, rt, value state; head/tail pointers wrap modulo DEPTH; count disambiguates full versus empty.
REQ-013 SHALL compute alloc_ready = (DEPTH - count ≥ ALLOC_W) from registered count only, independent of same-cycle commits.
REQ-014 SHALL grant lane i, when alloc_valid[i], the index tail + (number of valid lanes below i), combinationally, with lanes packed in program order; alloc_idx for invalid lanes is don't-care.
REQ-015 SHALL, on the clk edge with alloc_ready=1 and flush=0, set granted entries busy=1, done=0, rt=alloc_rt; tail advances by popcount(alloc_valid); when alloc_ready=0 all requests are ignored.
REQ-016 SHALL, per cdb_valid port, write value and set done=1 at the edge only if the target entry is busy; writes to non-busy entries are dropped; on duplicate cdb_idx the highest-numbered port wins.
REQ-017 SHALL drive commit_valid[k]=1 combinationally iff entries head..head+k are all busy and done (contiguous from head, stopping at first not-done), with commit_rt/data/idx taken from entry head+k.
REQ-018 SHALL, at the edge, clear busy/done of committed entries and advance head by the commit count; count_next = count + allocs − commits.
REQ-019 SHALL make CDB writes visible on rob_output_valid/values and commit outputs one cycle after the write edge; no same-cycle CDB-to-commit bypass.
REQ-020 SHALL, on flush=1 with flush_idx busy, clear busy/done of every entry younger than flush_idx, set tail=flush_idx+1, drop that cycle's allocations and any CDB writes to flushed entries, and still perform that cycle's commits; count_next = (tail_new − head_next) mod DEPTH, with value DEPTH when the buffer was full and no entry was flushed or committed.
REQ-021 SHALL ignore flush when flush_idx is not busy.

Reset
REQ-022 SHALL, while rst=1 at an edge: clear head, tail, count, and all busy/done flags; outputs then read commit_valid=0, rob_output_valid=0, alloc_ready=1, empty=1, full=0; rst overrides alloc, cdb and flush.

Verification (defaults)
REQ-023 Reset, then alloc_valid=4'b1011 with rt 1,2,_,3 -> alloc_idx lanes 0,1,3 = 0,1,2; next cycle count=3, tail=3.
REQ-024 Fill 16 entries over 4 cycles -> full=1, alloc_ready=0; a fifth alloc burst is ignored, count stays 16.
REQ-025 Entries 0..3 busy; CDB marks 0,1,3 done -> next cycle commit_valid=4'b0011, commit_idx 0,1; after the edge head=2.
REQ-026 Wrap-around: head=14, count=4 -> commits of entries 14,15,0,1 in one cycle give head=2, empty=1.
REQ-027 Entries 0..7 busy, flush_idx=3 plus CDB to entry 5 in the same cycle -> tail=4, count=4, entry 5 not done; allocations resume at index 4.
REQ-028 Same-cycle commit of 2 plus alloc of 4 at count=12 -> alloc_ready=1, count_next=14.
